cla_pipe_adder: RTL
===================

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 128, operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 32, bits resolved per pipeline stage; STAGES = WIDTH/SEG (default 4).
REQ-003 SHALL have ports: clk  in  1  rising-edge clock.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: in_valid  in  1  operand beat valid.
REQ-006 SHALL have ports: in_ready  out  1  block accepts a beat this cycle.
REQ-007 SHALL have ports: sub  in  1  1 = subtract (a - b), 0 = add.
REQ-008 SHALL have ports: cin  in  1  carry-in, used only when sub=0.
REQ-009 SHALL have ports: a, b  in  WIDTH  operands.
REQ-010 SHALL have ports: out_valid  out  1  result valid.
REQ-011 SHALL have ports: out_ready  in  1  downstream accepts the result.
REQ-012 SHALL have ports: s  out  WIDTH  sum/difference.
REQ-013 SHALL have ports: cout  out  1  carry out of bit WIDTH-1.
REQ-014 SHALL have ports: gen, prop  out  1 each  group generate/propagate over all WIDTH bits.

Function
REQ-015 Effective operand SHALL be b when sub=0 and ~b when sub=1; effective carry-in SHALL be cin when sub=0 and 1 when sub=1.
REQ-016 Result SHALL satisfy {cout,s} = a + b_eff + cin_eff, modulo 2^(WIDTH+1).
REQ-017 Each stage SHALL resolve one SEG-bit slice with 4-bit carry-lookahead groups combined hierarchically (group g/p, c_next = g | p&c), least-significant slice first.
REQ-018 Inter-stage carry, unresolved operand slices and completed sum slices SHALL be registered per stage (skew/deskew), so each stage contains one SEG-bit CLA only.
REQ-019 gen/prop SHALL accumulate across stages as G = g_hi | p_hi&G_lo, P = p_hi&P_lo, and be presented with the same beat's s.
REQ-020 Latency SHALL be exactly STAGES cycles from accepted beat (in_valid&in_ready) to out_valid, with no stall.
REQ-021 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-022 Pipeline enable SHALL be en = out_ready | ~out_valid; in_ready SHALL equal en.
REQ-023 When en=0 all stage registers SHALL hold; when en=1 every stage SHALL advance, empty slots propagating as bubbles (valid=0).
REQ-024 out_valid, s, cout, gen and prop SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Beats SHALL leave in acceptance order, none dropped or duplicated.
REQ-026 in_valid while in_ready=0 SHALL be ignored; the source holds the beat.
REQ-027 WIDTH not a multiple of SEG, or SEG not a multiple of 4, SHALL stop elaboration.
REQ-028 STAGES=1 SHALL give a single registered stage with latency 1.

Reset
REQ-029 rst_n=0 SHALL immediately clear all stage valid bits, out_valid, s, cout, gen, prop (and ovf, if present) to 0, regardless of clk.
REQ-030 Beats in flight at reset SHALL be discarded.
REQ-031 in_ready SHALL read 1 during reset and on the first edge after release.
REQ-032 The first beat accepted after release SHALL appear STAGES cycles later.

Configuration
REQ-033 Macro CLA_PIPE_OVF_EN defined: SHALL add output ovf (1 bit), two's-complement overflow of the result (carry into MSB xor cout), aligned with s; reset value 0.
REQ-034 CLA_PIPE_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=128, SEG=32)
REQ-035 a=all-ones, b=0, cin=1, sub=0 -> 4 cycles later s=0, cout=1, prop=1, gen=0.
REQ-036 sub=1, a=5, b=7 -> s=2^128-2 (0xFFFF...FFFE), cout=0; a=7, b=5 -> s=2, cout=1.
REQ-037 8 back-to-back random beats, out_ready=1 -> 8 results on consecutive cycles, in order, matching the reference model.
REQ-038 Continuous in_valid, out_ready=0 for 10 cycles -> in_ready=0 once out_valid=1, s stable; after release no loss or duplication.
REQ-039 rst_n pulsed low with 3 beats in flight -> out_valid=0 at once, no stale result afterwards, next beat returns 4 cycles after acceptance.
REQ-040 With CLA_PIPE_OVF_EN: a=0x7FFF...FFFF, b=1, sub=0 -> ovf=1, cout=0; a=1, b=1 -> ovf=0.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one SEG-bit slice per stage, LSB first.
// Optional two's-complement overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe_adder #(
   parameter int WIDTH = 128,
   parameter int SEG   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             gen,
   output logic             prop
`ifdef CLA_PIPE_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = WIDTH / SEG;
   localparam int LAST   = STAGES - 1;

   if ((SEG < 4) || ((SEG % 4) != 0) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a multiple of SEG, SEG a multiple of 4");
   end

   // Returns {group_g, group_p, sum} for one slice: 4-bit lookahead
   // groups chained through their group generate/propagate.
   function automatic logic [SEG+1:0] cla_seg(
      input logic [SEG-1:0] x,
      input logic [SEG-1:0] y,
      input logic           ci
   );
      logic [SEG-1:0] g;
      logic [SEG-1:0] p;
      logic [SEG-1:0] cv;
      logic           c;
      logic           g4;
      logic           p4;
      logic           gg;
      logic           pp;
      g  = x & y;
      p  = x ^ y;
      cv = '0;
      c  = ci;
      gg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < SEG / 4; j++) begin
         cv[4*j]   = c;
         cv[4*j+1] = g[4*j] | (p[4*j] & c);
         cv[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                   | (p[4*j+1] & p[4*j] & c);
         cv[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                   | (p[4*j+2] & p[4*j+1] & g[4*j])
                   | (p[4*j+2] & p[4*j+1] & p[4*j] & c);
         g4 = g[4*j+3] | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         p4 = &p[4*j +: 4];
         c  = g4 | (p4 & c);
         gg = g4 | (p4 & gg);
         pp = p4 & pp;
      end
      return {gg, pp, p ^ cv};
   endfunction

   logic             en;
   logic             pv [STAGES];
   logic             pc [STAGES];
   logic             pg [STAGES];
   logic             pp [STAGES];
   logic [WIDTH-1:0] pa [STAGES];
   logic [WIDTH-1:0] pb [STAGES];
   logic [WIDTH-1:0] ps [STAGES];

   // A stalled output freezes the whole pipe; otherwise bubbles advance too.
   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      logic             xv;
      logic             xc;
      logic             xg;
      logic             xp;
      logic [WIDTH-1:0] xa;
      logic [WIDTH-1:0] xb;
      logic [WIDTH-1:0] xs;
      logic [WIDTH-1:0] ns;
      logic [SEG+1:0]   r;
      logic             rv;
      logic             rc;
      logic             rg;
      logic             rp;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [WIDTH-1:0] rs;
      logic             unused_ops;

      if (k == 0) begin : g_src
         assign xv = in_valid;
         assign xa = a;
         assign xb = sub ? ~b : b;
         assign xc = sub | cin;
         assign xs = '0;
         assign xg = 1'b0;
         assign xp = 1'b1;
      end else begin : g_src
         assign xv = pv[k-1];
         assign xa = pa[k-1];
         assign xb = pb[k-1];
         assign xc = pc[k-1];
         assign xs = ps[k-1];
         assign xg = pg[k-1];
         assign xp = pp[k-1];
      end

      assign r = cla_seg(xa[k*SEG +: SEG], xb[k*SEG +: SEG], xc);

      always_comb begin
         ns = xs;
         ns[k*SEG +: SEG] = r[SEG-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rv <= 1'b0;
            rc <= 1'b0;
            rg <= 1'b0;
            rp <= 1'b0;
            ra <= '0;
            rb <= '0;
            rs <= '0;
         end else if (en) begin
            rv <= xv;
            rc <= r[SEG+1] | (r[SEG] & xc);
            rg <= r[SEG+1] | (r[SEG] & xg);
            rp <= r[SEG] & xp;
            ra <= xa;
            rb <= xb;
            rs <= ns;
         end
      end

      assign pv[k] = rv;
      assign pc[k] = rc;
      assign pg[k] = rg;
      assign pp[k] = rp;
      assign pa[k] = ra;
      assign pb[k] = rb;
      assign ps[k] = rs;
      // Resolved operand slices are carried but never read again.
      assign unused_ops = ^{ra, rb};
   end

   assign out_valid = pv[LAST];
   assign s         = ps[LAST];
   assign cout      = pc[LAST];
   assign gen       = pg[LAST];
   assign prop      = pp[LAST];

`ifdef CLA_PIPE_OVF_EN
   // Carry into the MSB is a^b^s at that bit.
   assign ovf = pa[LAST][WIDTH-1] ^ pb[LAST][WIDTH-1]
              ^ ps[LAST][WIDTH-1] ^ pc[LAST];
`endif

endmodule
